// File: rtl/gray_pkg.sv
// Shared mode encodings and width-generic binary/Gray conversion helpers.
// Used by gray_codec_stream; the adjacency check is enabled with GRAY_ADJ_CHECK_EN.
package gray_pkg;

  localparam logic MODE_BIN2GRAY = 1'b0;
  localparam logic MODE_GRAY2BIN = 1'b1;

  // Helpers work on zero-extended words up to MAX_WIDTH bits.
  // Zero-extension leaves the low WIDTH result bits unchanged in both directions.
  localparam int MAX_WIDTH = 64;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_adj_checker.sv
// Flags mode-1 words that differ from the previous accepted mode-1 word in more than one bit.
// Only instantiated when GRAY_ADJ_CHECK_EN is defined.
module gray_adj_checker
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_accept,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_adjErr
);

  logic [WIDTH-1:0] r_hist;
  logic             r_histValid;
  logic [WIDTH-1:0] w_diff;
  logic             w_multiBit;

  // Clearing the lowest set bit leaves something only if two or more bits differ.
  assign w_diff     = i_data ^ r_hist;
  assign w_multiBit = |(w_diff & (w_diff - WIDTH'(1)));
  assign o_adjErr   = r_histValid && (i_mode == MODE_GRAY2BIN) && w_multiBit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist      <= '0;
      r_histValid <= 1'b0;
    end else if (i_accept && (i_mode == MODE_GRAY2BIN)) begin
      r_hist      <= i_data;
      r_histValid <= 1'b1;
    end
  end

endmodule

// File: rtl/gray_codec_stream.sv
// Registered binary<->Gray converter with a one-entry valid/ready output stage.
// Define GRAY_ADJ_CHECK_EN to drive adj_err from gray_adj_checker; otherwise adj_err is 0.
module gray_codec_stream
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             adj_err
);

  logic                 r_valid;
  logic [WIDTH-1:0]     r_data;
  logic                 r_mode;
  logic                 w_accept;
  logic [MAX_WIDTH-1:0] w_ext;
  logic [MAX_WIDTH-1:0] w_convWide;
  logic [WIDTH-1:0]     w_conv;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  assign w_ext      = MAX_WIDTH'(in_data);
  assign w_convWide = (in_mode == MODE_GRAY2BIN) ? gray2bin(w_ext) : bin2gray(w_ext);
  assign w_conv     = w_convWide[WIDTH-1:0];

  generate
    if (WIDTH < MAX_WIDTH) begin : g_upper
      logic w_unusedUpper;
      assign w_unusedUpper = ^w_convWide[MAX_WIDTH-1:WIDTH];
    end
  endgenerate

  // An accept always overwrites the register; a lone transfer only drops valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mode  <= MODE_BIN2GRAY;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_conv;
      r_mode  <= in_mode;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_mode  = r_mode;

`ifdef GRAY_ADJ_CHECK_EN
  logic r_adjErr;
  logic w_adjErr;

  gray_adj_checker #(
    .WIDTH(WIDTH)
  ) u_adjChecker (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_accept(w_accept),
    .i_mode  (in_mode),
    .i_data  (in_data),
    .o_adjErr(w_adjErr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_adjErr <= 1'b0;
    end else if (w_accept) begin
      r_adjErr <= w_adjErr;
    end
  end

  assign adj_err = r_adjErr;
`else
  assign adj_err = 1'b0;
`endif

endmodule
